serial_sub: RTL

//  Bit-serial, LSB-first WIDTH-bit subtractor: diff = a - b - b_in, one bit per clock.

---
 rtl/serial_sub_pkg.sv | 9 +
 rtl/full_sub_str.sv | 24 ++
 rtl/serial_sub.sv | 71 +++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encodings for the bit-serial subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam state_t S_DEFAULT = S_DONE;
endpackage

// File: rtl/full_sub_str.sv
// full_sub_str: gate-level full subtractor, d = x-y-bw with borrow out
module full_sub_str (
    output logic b_out,
    output logic d,
    input  logic x,
    input  logic y,
    input  logic bw
);
    logic nx, ny, nbw, t1, t2, t, nt, t3, t4, p1, p2, p3;
    not (nx, x);
    not (ny, y);
    not (nbw, bw);
    and (t1, x, ny);
    and (t2, nx, y);
    or  (t, t1, t2);
    not (nt, t);
    and (t3, t, nbw);
    and (t4, nt, bw);
    or  (d, t3, t4);
    and (p1, nx, y);
    and (p2, nx, bw);
    and (p3, y, bw);
    or  (b_out, p1, p2, p3);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial subtractor diff = a - b - b_in with start/done handshake
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0] count;
    logic borrow, d, bw_n;
    full_sub_str u_fs (.b_out(bw_n), .d(d), .x(a_sr[0]), .y(b_sr[0]), .bw(borrow));
    // b_sr doubles as the result register: each consumed subtrahend bit frees room for a diff bit at the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
            count  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    borrow <= b_in;
                    count  <= '0;
                    busy   <= 1'b1;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= {d, b_sr[WIDTH-1:1]};
                    borrow <= bw_n;
                    count  <= (count == LAST) ? count : count + 1'b1;
                    if (count == LAST) begin
                        diff  <= {d, b_sr[WIDTH-1:1]};
                        b_out <= bw_n;
                        // on the last bit the cell inputs are exactly a[MSB] and b[MSB]
                        ovf   <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
